// File: rtl/bfm_ahb_arbiter_if.sv
// AHB arbitration bundle: master requests and transfer info in, grant and
// address/data-phase ownership out.
interface bfm_ahb_arbiter_if;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_D;
    logic       HMASTLOCK;

    // The arbiter is the receiving side of the requests.
    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
    );
endinterface

// File: rtl/bfm_ahb_arbiter.sv
// Four-master AHB round-robin arbiter with lock and fixed-length burst
// protection, registered one-hot grant and address/data-phase owner tracking.
module bfm_ahb_arbiter #(
    parameter int TPD = 1
) (
    input logic               HCLK,
    input logic               HRESET,
    bfm_ahb_arbiter_if.slave  bus
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    // Outputs are zero-delay in hardware; TPD only matters to timed models.
    if (TPD < 0) begin : g_tpd_chk
        $error("TPD must be non-negative");
    end

    logic [3:0] grant_p0;
    logic [1:0] mst_p1;
    logic [1:0] mst_p2;
    logic       mlock_p1;
    logic [3:0] beat_cnt;
    logic [3:0] cnt_nxt;
    logic [1:0] rr_ptr;
    logic [1:0] grant_idx;
    logic       burst_start;
    logic       hold;
    logic       arb;

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Scan from farthest to nearest so the master right after ptr wins.
    function automatic logic [3:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
        logic [3:0] pick;
        logic [1:0] idx;
        pick = 4'b0001;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) pick = 4'b0001 << idx;
        end
        return pick;
    endfunction

    assign grant_idx = oh2idx(grant_p0);

    // The first beat of a fixed-length burst holds the bus before its count is loaded.
    assign burst_start = (bus.HTRANS == TR_NONSEQ) && (bus.HBURST >= 3'd2);
    assign hold = (bus.HLOCK[mst_p1] && bus.HBUSREQ[mst_p1]) || (beat_cnt != 4'd0) || burst_start;
    assign arb  = bus.HREADY && !hold;

    always_comb begin
        cnt_nxt = beat_cnt;
        case (bus.HTRANS)
            TR_IDLE: cnt_nxt = 4'd0;
            TR_BUSY: cnt_nxt = beat_cnt;
            TR_NONSEQ: begin
                case (bus.HBURST)
                    3'd2, 3'd3: cnt_nxt = 4'd3;
                    3'd4, 3'd5: cnt_nxt = 4'd7;
                    3'd6, 3'd7: cnt_nxt = 4'd15;
                    default:    cnt_nxt = 4'd0;
                endcase
            end
            TR_SEQ: if (beat_cnt != 4'd0) cnt_nxt = beat_cnt - 4'd1;
            default: cnt_nxt = beat_cnt;
        endcase
    end

    // p0: grant; p1: address-phase owner; p2: data-phase owner
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_p0 <= 4'b0001;
            mst_p1   <= 2'd0;
            mst_p2   <= 2'd0;
            mlock_p1 <= 1'b0;
            beat_cnt <= 4'd0;
            rr_ptr   <= 2'd0;
        end else begin
            if (arb) grant_p0 <= rr_pick(rr_ptr, bus.HBUSREQ);
            if (bus.HREADY) begin
                mst_p1   <= grant_idx;
                mlock_p1 <= bus.HLOCK[grant_idx];
                mst_p2   <= mst_p1;
                beat_cnt <= cnt_nxt;
                if (grant_idx != mst_p1) rr_ptr <= grant_idx;
            end
        end
    end

    assign bus.HGRANT    = grant_p0;
    assign bus.HMASTER   = mst_p1;
    assign bus.HMASTER_D = mst_p2;
    assign bus.HMASTLOCK = mlock_p1;

endmodule

// File: tb/tb_bfm_ahb_arbiter.sv
// Bench for bfm_ahb_arbiter: vector table, directed multi-cycle scenarios and
// randomized traffic against an arithmetic reference model.
module tb_bfm_ahb_arbiter;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    bfm_ahb_arbiter_if bus();

    bfm_ahb_arbiter #(.TPD(1)) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: plain integers describing ownership.
    int m_grant, m_master, m_master_d, m_cnt, m_last;
    bit m_lock;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lck;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic [3:0] g;
        logic [1:0] m;
        logic [1:0] md;
        logic       ml;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] lck,
                                input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                                input logic [3:0] g, input logic [1:0] m, input logic [1:0] md,
                                input logic ml);
        vec_t v;
        v.rst = rst; v.req = req; v.lck = lck; v.tr = tr; v.bu = bu; v.rdy = rdy;
        v.g = g; v.m = m; v.md = md; v.ml = ml;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int blen(input logic [2:0] b);
        case (b)
            3'd0:       return 1;
            3'd1:       return 0;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    task automatic model_step();
        int  ng, len, cand;
        bit  hold, found;
        len = blen(bus.HBURST);
        if (HRESET) begin
            m_grant = 0; m_master = 0; m_master_d = 0; m_lock = 0; m_cnt = 0; m_last = 0;
        end else begin
            hold = (bus.HLOCK[m_master] && bus.HBUSREQ[m_master]) || (m_cnt > 0) ||
                   (bus.HTRANS == 2'd2 && len > 1);
            ng = m_grant;
            if (bus.HREADY && !hold) begin
                ng = 0;
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    cand = (m_last + k) % 4;
                    if (!found && bus.HBUSREQ[cand]) begin
                        ng = cand;
                        found = 1;
                    end
                end
            end
            if (bus.HREADY) begin
                if (m_grant != m_master) m_last = m_grant;
                m_master_d = m_master;
                m_master   = m_grant;
                m_lock     = bus.HLOCK[m_grant];
                case (bus.HTRANS)
                    2'd0: m_cnt = 0;
                    2'd1: m_cnt = m_cnt;
                    2'd2: m_cnt = (len > 1) ? len - 1 : 0;
                    default: if (m_cnt > 0) m_cnt = m_cnt - 1;
                endcase
            end
            m_grant = ng;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge HCLK);
        #1;
        check("grant",     32'(bus.HGRANT),    32'(1) << m_grant);
        check("hmaster",   32'(bus.HMASTER),   32'(m_master));
        check("hmaster_d", 32'(bus.HMASTER_D), 32'(m_master_d));
        check("hmastlock", 32'(bus.HMASTLOCK), 32'(m_lock));
        check("onehot",    32'($onehot(bus.HGRANT)), 32'(1));
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] lck,
                         input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        HRESET = rst; bus.HBUSREQ = req; bus.HLOCK = lck;
        bus.HTRANS = tr; bus.HBURST = bu; bus.HREADY = rdy;
    endtask

    initial begin
        // Idle-to-request, parking, round-robin rotation, wait state.
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 4'b0001, 2'd0, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 4'b0100, 2'd0, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 4'b0100, 2'd2, 2'd0, 0));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 2'd0, 3'd0, 1, 4'b0100, 2'd2, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 4'b0001, 2'd2, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 4'b0001, 2'd0, 2'd2, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 2'd0, 3'd0, 1, 4'b0001, 2'd0, 2'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 4'b0010, 2'd0, 2'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 4'b0010, 2'd1, 2'd0, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 4'b0100, 2'd1, 2'd1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 4'b0100, 2'd2, 2'd1, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 4'b1000, 2'd2, 2'd2, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 4'b1000, 2'd3, 2'd2, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 4'b0001, 2'd3, 2'd3, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 4'b0001, 2'd0, 2'd3, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 0, 4'b0001, 2'd0, 2'd3, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 2'd2, 3'd0, 1, 4'b0010, 2'd0, 2'd0, 0));

        drive(1, 4'b0000, 4'b0000, 2'd0, 3'd0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].lck, tbl[i].tr, tbl[i].bu, tbl[i].rdy);
            tick();
            check($sformatf("vec%0d.grant", i),     32'(bus.HGRANT),    32'(tbl[i].g));
            check($sformatf("vec%0d.hmaster", i),   32'(bus.HMASTER),   32'(tbl[i].m));
            check($sformatf("vec%0d.hmaster_d", i), 32'(bus.HMASTER_D), 32'(tbl[i].md));
            check($sformatf("vec%0d.hmastlock", i), 32'(bus.HMASTLOCK), 32'(tbl[i].ml));
        end

        // Lock hold: master 0 locked while everyone requests.
        drive(1, 4'b1111, 4'b0001, 2'd2, 3'd0, 1);
        tick();
        HRESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("lock.grant", 32'(bus.HGRANT), 32'(4'b0001));
            check("lock.hmastlock", 32'(bus.HMASTLOCK), 32'(1));
        end
        bus.HLOCK = 4'b0000;
        tick();
        check("lock.release", 32'(bus.HGRANT), 32'(4'b0010));

        // Burst protection: master 1 INCR8 with a wait state, master 3 waiting.
        drive(1, 4'b1010, 4'b0000, 2'd0, 3'd0, 1);
        tick();
        HRESET = 1'b0;
        tick();
        tick();
        check("burst.owner", 32'(bus.HMASTER), 32'(1));
        drive(0, 4'b1010, 4'b0000, 2'd2, 3'd5, 1);
        tick();
        check("burst.nonseq", 32'(bus.HGRANT), 32'(4'b0010));
        for (int b = 1; b <= 7; b++) begin
            bus.HTRANS = 2'd3;
            if (b == 3) begin
                bus.HREADY = 1'b0;
                tick();
                check("burst.wait", 32'(bus.HGRANT), 32'(4'b0010));
                bus.HREADY = 1'b1;
            end
            tick();
            check($sformatf("burst.seq%0d", b), 32'(bus.HGRANT), 32'(4'b0010));
        end
        bus.HTRANS = 2'd0;
        tick();
        check("burst.handover", 32'(bus.HGRANT), 32'(4'b1000));

        // Early termination: master 2 WRAP4 cut short by IDLE, master 0 waiting.
        drive(1, 4'b0101, 4'b0000, 2'd0, 3'd0, 1);
        tick();
        HRESET = 1'b0;
        tick();
        tick();
        check("early.owner", 32'(bus.HMASTER), 32'(2));
        drive(0, 4'b0101, 4'b0000, 2'd2, 3'd2, 1);
        tick();
        bus.HTRANS = 2'd3;
        tick();
        check("early.beat2", 32'(bus.HGRANT), 32'(4'b0100));
        bus.HTRANS = 2'd0;
        tick();
        check("early.idle", 32'(bus.HGRANT), 32'(4'b0100));
        tick();
        check("early.regrant", 32'(bus.HGRANT), 32'(4'b0001));

        // Reset in the middle of a locked INCR16 by master 3.
        drive(1, 4'b1000, 4'b1000, 2'd0, 3'd0, 1);
        tick();
        HRESET = 1'b0;
        tick();
        tick();
        drive(0, 4'b1000, 4'b1000, 2'd2, 3'd7, 1);
        tick();
        bus.HTRANS = 2'd3;
        tick();
        tick();
        check("rstmid.owner", 32'(bus.HMASTER), 32'(3));
        check("rstmid.lock", 32'(bus.HMASTLOCK), 32'(1));
        HRESET = 1'b1;
        tick();
        check("rstmid.grant", 32'(bus.HGRANT), 32'(4'b0001));
        check("rstmid.hmaster", 32'(bus.HMASTER), 32'(0));
        check("rstmid.hmaster_d", 32'(bus.HMASTER_D), 32'(0));
        check("rstmid.hmastlock", 32'(bus.HMASTLOCK), 32'(0));
        drive(0, 4'b0010, 4'b0000, 2'd0, 3'd0, 1);
        tick();
        check("rstmid.first_arb", 32'(bus.HGRANT), 32'(4'b0010));

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            HRESET      = ($urandom_range(0, 63) == 0);
            bus.HBUSREQ = 4'($urandom);
            bus.HLOCK   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            bus.HTRANS  = 2'($urandom);
            bus.HBURST  = 3'($urandom);
            bus.HREADY  = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
